// File: rtl/clk_period_monitor_if.sv
// rtl/clk_period_monitor_if.sv - signal bundle between a divided-clock source/consumer and clk_period_monitor
// Purpose: groups the monitor's control inputs and its tick/measurement/status outputs.
// Signals:
//   en, clk_in, clr_fault                         driven by the master (controller side)
//   rise_tick, fall_tick, meas_valid, half_period,
//   locked, fault_fast, fault_slow,
//   min_half, max_half                            driven by the slave (the monitor)
// Modports: master = controller/consumer, slave = clk_period_monitor.
interface clk_period_monitor_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             clk_in;
  logic             clr_fault;
  logic             rise_tick;
  logic             fall_tick;
  logic             meas_valid;
  logic [CNT_W-1:0] half_period;
  logic             locked;
  logic             fault_fast;
  logic             fault_slow;
  logic [CNT_W-1:0] min_half;
  logic [CNT_W-1:0] max_half;

  modport master (
    output en, clk_in, clr_fault,
    input  rise_tick, fall_tick, meas_valid, half_period,
    input  locked, fault_fast, fault_slow, min_half, max_half
  );

  modport slave (
    input  en, clk_in, clr_fault,
    output rise_tick, fall_tick, meas_valid, half_period,
    output locked, fault_fast, fault_slow, min_half, max_half
  );
endinterface

// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - measures the half-period of a divided clock and reports lock/fault
// Purpose: samples clk_in in the clk100MHz domain, emits rise/fall ticks, measures the cycle
//   count between consecutive edges, and checks it against EXP_HALF +/- TOL.
// Ports:
//   clk100MHz  system clock
//   rst        synchronous reset, active low
//   mon        clk_period_monitor_if.slave: en, clk_in, clr_fault in; ticks, meas_valid,
//              half_period, locked, fault_fast, fault_slow, min_half, max_half out
// Build option: define MON_HIST_EN to build the min_half/max_half history registers;
//   otherwise both are tied to 0.
module clk_period_monitor #(
  parameter int EXP_HALF = 10000,
  parameter int TOL      = 16,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 32
) (
  input logic                clk100MHz,
  input logic                rst,
  clk_period_monitor_if.slave mon
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] HALF_LO      = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HALF_HI      = CNT_W'(EXP_HALF + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_MEAS = CNT_W'(EXP_HALF + TOL + 1);

  logic             sync1, sync2, sync3;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;

  logic             rise_tick_q, fall_tick_q, meas_valid_q;
  logic [CNT_W-1:0] half_period_q;
  logic             locked_q, fault_fast_q, fault_slow_q;

  logic             edge_seen;
  logic [CNT_W-1:0] meas;
  logic             meas_good;
  logic             meas_fast;
  logic             timeout;
  logic             meas_strobe;

  always_comb begin
    edge_seen   = sync2 ^ sync3;
    // Saturate so a stuck counter never wraps into a plausible measurement.
    meas        = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    meas_good   = (meas >= HALF_LO) && (meas <= HALF_HI);
    meas_fast   = meas < HALF_LO;
    // An edge in the timeout cycle takes priority and is measured instead.
    timeout     = !edge_seen && (meas == TIMEOUT_MEAS);
    meas_strobe = mon.en && edge_seen && ((state == MEASURE) || (state == LOCKED));
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      sync3         <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      good_cnt      <= '0;
      rise_tick_q   <= 1'b0;
      fall_tick_q   <= 1'b0;
      meas_valid_q  <= 1'b0;
      half_period_q <= '0;
      locked_q      <= 1'b0;
      fault_fast_q  <= 1'b0;
      fault_slow_q  <= 1'b0;
    end else begin
      // Synchroniser keeps running in IDLE so re-enabling does not see a stale level as an edge.
      sync1        <= mon.clk_in;
      sync2        <= sync1;
      sync3        <= sync2;
      rise_tick_q  <= 1'b0;
      fall_tick_q  <= 1'b0;
      meas_valid_q <= 1'b0;

      // Fault setting below comes later in the block, so a same-cycle fault wins over the clear.
      if (mon.clr_fault) begin
        fault_fast_q <= 1'b0;
        fault_slow_q <= 1'b0;
      end

      if (!mon.en) begin
        state    <= IDLE;
        cnt      <= '0;
        good_cnt <= '0;
        locked_q <= 1'b0;
      end else if (state == IDLE) begin
        state <= ACQUIRE;
      end else begin
        rise_tick_q <= edge_seen & sync2;
        fall_tick_q <= edge_seen & ~sync2;

        if (edge_seen) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end

        if (meas_strobe) begin
          meas_valid_q  <= 1'b1;
          half_period_q <= meas;
          if (meas_good) begin
            if (state == MEASURE) begin
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                good_cnt <= GW'(LOCK_CNT);
                locked_q <= 1'b1;
                state    <= LOCKED;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end
          end else begin
            // Any out-of-window measurement breaks the run of good ones; only short ones are faults
            // because long gaps are already reported by the timeout.
            good_cnt <= '0;
            locked_q <= 1'b0;
            state    <= MEASURE;
            if (meas_fast) begin
              fault_fast_q <= 1'b1;
            end
          end
        end else if (edge_seen) begin
          // First edge after acquisition only establishes a reference point.
          good_cnt <= '0;
          state    <= MEASURE;
        end else if (timeout) begin
          fault_slow_q <= 1'b1;
          locked_q     <= 1'b0;
          good_cnt     <= '0;
          cnt          <= '0;
          state        <= ACQUIRE;
        end
      end
    end
  end

  assign mon.rise_tick   = rise_tick_q;
  assign mon.fall_tick   = fall_tick_q;
  assign mon.meas_valid  = meas_valid_q;
  assign mon.half_period = half_period_q;
  assign mon.locked      = locked_q;
  assign mon.fault_fast  = fault_fast_q;
  assign mon.fault_slow  = fault_slow_q;

`ifdef MON_HIST_EN
  logic [CNT_W-1:0] min_half_q, max_half_q;

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      min_half_q <= '0;
      max_half_q <= '0;
    end else begin
      if (mon.clr_fault) begin
        min_half_q <= CNT_MAX;
        max_half_q <= '0;
      end
      // A measurement in the clear cycle becomes the first entry of the new history.
      if (meas_strobe) begin
        if (mon.clr_fault || (meas < min_half_q)) begin
          min_half_q <= meas;
        end
        if (mon.clr_fault || (meas > max_half_q)) begin
          max_half_q <= meas;
        end
      end
    end
  end

  assign mon.min_half = min_half_q;
  assign mon.max_half = max_half_q;
`else
  assign mon.min_half = '0;
  assign mon.max_half = '0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb/tb_clk_period_monitor.sv - directed self-checking bench for clk_period_monitor
`timescale 1ns/1ps
module tb_clk_period_monitor;

  localparam int EXP_HALF = 200;
  localparam int TOL      = 16;
  localparam int LOCK_CNT = 4;
  localparam int CNT_W    = 32;
  localparam int LO       = EXP_HALF - TOL;
  localparam int HI       = EXP_HALF + TOL;

  logic clk100MHz = 1'b0;
  logic rst       = 1'b0;

  always #5 clk100MHz = ~clk100MHz;

  clk_period_monitor_if #(.CNT_W(CNT_W)) mon ();

  clk_period_monitor #(
    .EXP_HALF (EXP_HALF),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .mon       (mon)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event recorder, sampled on the falling edge.
  int   cyc = 0;
  int   n_rise = 0, n_fall = 0, n_meas = 0;
  int   rise_cyc = 0, fall_cyc = 0, mv_cyc = 0, lock_cyc = 0, slow_cyc = 0;
  logic lock_d = 1'b0, slow_d = 1'b0;

  always @(negedge clk100MHz) begin
    cyc++;
    if (mon.rise_tick === 1'b1) begin n_rise++; rise_cyc = cyc; end
    if (mon.fall_tick === 1'b1) begin n_fall++; fall_cyc = cyc; end
    if (mon.meas_valid === 1'b1) begin n_meas++; mv_cyc = cyc; end
    if (mon.locked === 1'b1 && !lock_d) lock_cyc = cyc;
    if (mon.fault_slow === 1'b1 && !slow_d) slow_cyc = cyc;
    lock_d = (mon.locked === 1'b1);
    slow_d = (mon.fault_slow === 1'b1);
  end

  // Toggle clk_in exactly n cycles after the previous toggle, then settle 6 cycles for checks.
  task automatic step(input int n);
    repeat (n - 6) @(posedge clk100MHz);
    #1 mon.clk_in = ~mon.clk_in;
    repeat (6) @(posedge clk100MHz);
    #1;
  endtask

  task automatic clr_pulse();
    @(posedge clk100MHz);
    #1 mon.clr_fault = 1'b1;
    @(posedge clk100MHz);
    #1 mon.clr_fault = 1'b0;
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic restart();
    @(posedge clk100MHz);
    #1 mon.en = 1'b0;
    clr_pulse();
    mon.en = 1'b1;
    repeat (2) @(posedge clk100MHz);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0, f0, m0, k;
    mon.en        = 1'b0;
    mon.clk_in    = 1'b0;
    mon.clr_fault = 1'b0;

    // Reset with clk_in toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk100MHz);
      #1 mon.clk_in = ~mon.clk_in;
    end
    @(negedge clk100MHz);
    #1;
    check("rst_flags", {mon.rise_tick, mon.fall_tick, mon.meas_valid,
                        mon.locked, mon.fault_fast, mon.fault_slow}, 6'b0);
    check("rst_half", mon.half_period, 0);
    check("rst_minmax", {mon.min_half, mon.max_half}, 0);
    check("rst_ticks", n_rise + n_fall + n_meas, 0);
    rst = 1'b1;

    // Nominal lock
    restart();
    r0 = n_rise; f0 = n_fall; m0 = n_meas;
    for (int i = 1; i <= 5; i++) begin
      step(EXP_HALF);
      if (i == 1) check("nom_first_nomeas", n_meas - m0, 0);
      if (i == 4) begin
        check("nom_meas4", n_meas - m0, 3);
        check("nom_unlocked4", mon.locked, 0);
      end
    end
    check("nom_meas_cnt", n_meas - m0, 4);
    check("nom_half", mon.half_period, EXP_HALF);
    check("nom_locked", mon.locked, 1);
    check("nom_lock_time", lock_cyc, mv_cyc);
    check("nom_rise_cnt", n_rise - r0, 3);
    check("nom_fall_cnt", n_fall - f0, 2);
    check("nom_tick_gap", rise_cyc - fall_cyc, EXP_HALF);
    check("nom_faults", {mon.fault_fast, mon.fault_slow}, 2'b00);

    // Fast clock
    restart();
    m0 = n_meas;
    step(150);
    check("fast_e1_nomeas", n_meas - m0, 0);
    check("fast_e1_ff", mon.fault_fast, 0);
    step(150);
    check("fast_e2_ff", mon.fault_fast, 1);
    check("fast_e2_half", mon.half_period, 150);
    check("fast_e2_locked", mon.locked, 0);
    repeat (50) @(posedge clk100MHz);
    #1 mon.clr_fault = 1'b1;
    @(posedge clk100MHz);
    #1 mon.clr_fault = 1'b0;
    @(posedge clk100MHz);
    #1;
    check("fast_clr", mon.fault_fast, 0);
    step(150 - 52);
    check("fast_reset", mon.fault_fast, 1);
    check("fast_locked", mon.locked, 0);

    // Stall and relock
    restart();
    check("stall_clr", {mon.fault_fast, mon.fault_slow}, 2'b00);
    for (int i = 0; i < 5; i++) step(EXP_HALF);
    check("stall_prelock", mon.locked, 1);
    m0 = n_meas;
    k = 0;
    while (mon.fault_slow !== 1'b1 && k < 1000) begin
      @(negedge clk100MHz);
      k++;
    end
    #1;
    check("stall_seen", mon.fault_slow, 1);
    check("stall_time", slow_cyc - mv_cyc, HI + 1);
    check("stall_unlock", mon.locked, 0);
    check("stall_nomeas", n_meas - m0, 0);
    step(100);
    for (int i = 0; i < 3; i++) step(EXP_HALF);
    check("relock_4edges", mon.locked, 0);
    step(EXP_HALF);
    check("relock_5edges", mon.locked, 1);
    check("relock_slow_sticky", mon.fault_slow, 1);

    // Window boundaries
    restart();
    step(EXP_HALF);
    step(LO);
    check("bnd_lo_half", mon.half_period, LO);
    check("bnd_lo_ff", mon.fault_fast, 0);
    step(HI);
    check("bnd_hi_half", mon.half_period, HI);
    step(EXP_HALF);
    step(EXP_HALF);
    check("bnd_locked", mon.locked, 1);
    m0 = n_meas;
    step(HI + 1);
    check("bnd_to_meas", n_meas - m0, 1);
    check("bnd_to_half", mon.half_period, HI + 1);
    check("bnd_to_flags", {mon.fault_fast, mon.fault_slow}, 2'b00);
    check("bnd_to_unlock", mon.locked, 0);
    step(LO - 1);
    check("bnd_short_ff", mon.fault_fast, 1);
    check("bnd_short_half", mon.half_period, LO - 1);

`ifdef MON_HIST_EN
    restart();
    check("hist_clr_min", mon.min_half, 32'hFFFF_FFFF);
    check("hist_clr_max", mon.max_half, 0);
    step(EXP_HALF);
    for (int i = 0; i < 2; i++) begin
      step(190);
      step(210);
    end
    check("hist_min", mon.min_half, 190);
    check("hist_max", mon.max_half, 210);
    clr_pulse();
    check("hist_reclr_min", mon.min_half, 32'hFFFF_FFFF);
    check("hist_reclr_max", mon.max_half, 0);
`else
    check("hist_off_min", mon.min_half, 0);
    check("hist_off_max", mon.max_half, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
